imem_boot_loader: RTL

Boot-time sequencer for the 128-word instruction memory. It receives a program as a byte stream with a valid/ready handshake and assembles little-endian 32-bit words. It writes those words through the instruction memory write port, and holds the CPU in reset until the image is fully written. It sits between the host/debug byte link and the instruction memory, and drives the CPU's run enable.

---
 rtl/imem_boot_loader_pkg.sv | 16 +
 rtl/imem_boot_loader.sv | 119 +++++++++++
 2 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
// The state enum is shared so other boot logic can decode loader state.
package imem_boot_loader_pkg;

   localparam int IMEM_DEPTH  = 128;
   localparam int IMEM_ADDR_W = 7;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: turns a length-prefixed byte stream into instruction memory
// word writes, holding the CPU in reset until the whole image is in place.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_run,
   output logic              load_err
);

   state_t            r_state;
   logic [15:0]       r_count;
   logic [ADDR_W:0]   r_widx;
   logic [1:0]        r_lane;
   logic [23:0]       r_word;

   logic              w_acc;
   logic [15:0]       w_len;
   logic [ADDR_W:0]   w_widx_nxt;

   assign in_ready = ((r_state == S_LEN_HI) ||
                      (r_state == S_LEN_LO) ||
                      (r_state == S_DATA)) && !reload;

   assign w_acc      = in_valid && in_ready;
   assign w_len      = {r_count[15:8], in_data};
   assign w_widx_nxt = r_widx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_LEN_HI;
         r_count   <= '0;
         r_widx    <= '0;
         r_lane    <= '0;
         r_word    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_run   <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (reload) begin
            // mem_addr/mem_wdata keep the last write; memory is untouched
            r_state  <= S_LEN_HI;
            r_count  <= '0;
            r_widx   <= '0;
            r_lane   <= '0;
            r_word   <= '0;
            cpu_run  <= 1'b0;
            load_err <= 1'b0;
         end else begin
            unique case (r_state)
               S_LEN_HI: begin
                  if (w_acc) begin
                     r_count[15:8] <= in_data;
                     r_state       <= S_LEN_LO;
                  end
               end
               S_LEN_LO: begin
                  if (w_acc) begin
                     r_count[7:0] <= in_data;
                     r_widx       <= '0;
                     r_lane       <= '0;
                     if (w_len == 16'd0) begin
                        r_state <= S_DONE;
                        cpu_run <= 1'b1;
                     end else if (w_len > 16'(DEPTH)) begin
                        r_state  <= S_ERR;
                        load_err <= 1'b1;
                     end else begin
                        r_state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (w_acc) begin
                     if (r_lane == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_widx[ADDR_W-1:0];
                        mem_wdata <= {in_data, r_word};
                        r_widx    <= w_widx_nxt;
                        r_lane    <= '0;
                        if (16'(w_widx_nxt) == r_count) begin
                           r_state <= S_DONE;
                        end
                     end else begin
                        // little-endian: earlier bytes shift toward bit 0
                        r_word <= {in_data, r_word[23:8]};
                        r_lane <= r_lane + 2'd1;
                     end
                  end
               end
               S_DONE: begin
                  cpu_run <= 1'b1;
               end
               S_ERR: begin
                  load_err <= 1'b1;
               end
               default: begin
                  r_state <= S_LEN_HI;
               end
            endcase
         end
      end
   end

endmodule
